// File: rtl/parallel_align.sv
// parallel_align: byte-stream word aligner for the BER receive path.
// Hunts SYNC_WORD at any of 8 bit offsets, then assembles 64-bit payload
// words at the found offset and tracks frame lock with a miss flywheel.
// Ports:
//   i_clk      clock
//   i_rstx     synchronous active-low reset (priority over i_clr)
//   i_clr      synchronous clear to reset state
//   i_dipush   i_din valid this cycle
//   i_din      raw byte, MSB received first
//   o_aligned  frame lock held
//   o_dopush   o_dout valid, one-cycle pulse per payload word
//   o_dout     payload word, first-received bit in o_dout[63]
//   o_init     one-cycle pulse: sync matched, payload follows
//   o_loss_cnt saturating lock-loss count (only with PARALLEL_ALIGN_STAT_EN)
// Build option: define PARALLEL_ALIGN_STAT_EN to add o_loss_cnt.
module parallel_align #(
    parameter logic [63:0] SYNC_WORD     = 64'hA5C3_5A3C_0FF0_F00F,
    parameter int          PAYLOAD_WORDS = 1024,
    parameter int          MISS_MAX      = 4
) (
    input  logic        i_clk,
    input  logic        i_rstx,
    input  logic        i_clr,
    input  logic        i_dipush,
    input  logic [7:0]  i_din,
    output logic        o_aligned,
    output logic        o_dopush,
    output logic [63:0] o_dout,
    output logic        o_init
`ifdef PARALLEL_ALIGN_STAT_EN
    ,
    output logic [15:0] o_loss_cnt
`endif
);
    localparam int CW = $clog2(PAYLOAD_WORDS + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [CW-1:0] CNT_SYNC  = CW'(PAYLOAD_WORDS);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        r_state;
    logic [71:0]   r_sr;
    logic [2:0]    r_ofs;
    logic [2:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic [MW-1:0] r_miss;
    logic          r_aligned;
    logic          r_dopush;
    logic [63:0]   r_dout;
    logic          r_init;

    logic [71:0]   w_sr;
    logic [63:0]   w_word;
    logic          w_hit;
    logic [2:0]    w_k;

    // All decisions use the shift register value after this cycle's push.
    assign w_sr   = {r_sr[63:0], i_din};
    assign w_word = w_sr[r_ofs +: 64];

    // Scan from the highest offset down so the lowest matching offset wins.
    always_comb begin
        w_hit = 1'b0;
        w_k   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_sr[k +: 64] == SYNC_WORD) begin
                w_hit = 1'b1;
                w_k   = 3'(k);
            end
        end
    end

`ifdef PARALLEL_ALIGN_STAT_EN
    logic [15:0] r_loss_cnt;
    assign o_loss_cnt = r_loss_cnt;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstx || i_clr) begin
            r_state   <= HUNT;
            r_sr      <= '0;
            r_ofs     <= '0;
            r_phase   <= '0;
            r_cnt     <= '0;
            r_miss    <= '0;
            r_aligned <= 1'b0;
            r_dopush  <= 1'b0;
            r_dout    <= '0;
            r_init    <= 1'b0;
`ifdef PARALLEL_ALIGN_STAT_EN
            r_loss_cnt <= '0;
`endif
        end else begin
            r_init   <= 1'b0;
            r_dopush <= 1'b0;
            if (i_dipush) begin
                r_sr <= w_sr;
                if (r_state == HUNT) begin
                    if (w_hit) begin
                        r_state   <= LOCK;
                        r_ofs     <= w_k;
                        r_init    <= 1'b1;
                        r_aligned <= 1'b1;
                        r_phase   <= '0;
                        r_cnt     <= '0;
                        r_miss    <= '0;
                    end
                end else begin
                    r_phase <= r_phase + 3'd1;
                    if (r_phase == 3'd7) begin
                        if (r_cnt != CNT_SYNC) begin
                            r_dout   <= w_word;
                            r_dopush <= 1'b1;
                            r_cnt    <= r_cnt + CW'(1);
                        end else begin
                            // Sync slot: never output, decides lock keep/flywheel/loss.
                            r_cnt <= '0;
                            if (w_word == SYNC_WORD) begin
                                r_init <= 1'b1;
                                r_miss <= '0;
                            end else if (r_miss != MISS_LAST) begin
                                r_miss <= r_miss + MW'(1);
                            end else begin
                                r_state   <= HUNT;
                                r_aligned <= 1'b0;
`ifdef PARALLEL_ALIGN_STAT_EN
                                if (r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    assign o_aligned = r_aligned;
    assign o_dopush  = r_dopush;
    assign o_dout    = r_dout;
    assign o_init    = r_init;
endmodule
